// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//   Pipeline hazard unit: selects operand forwarding for the ID-stage sources,
//   detects load-use hazards and (optionally) stalls on a busy multiply/divide
//   unit.
//
//   Optional feature: define HAZARD_MDU_STALL_EN to build the MDU busy counter
//   and the MDU stall. Without it mdu_busy is tied low and the MDU inputs are
//   ignored.
//
// Parameters
//   MULT_CYCLES  busy cycles for a multiply (1..63)
//   DIV_CYCLES   busy cycles for a divide   (1..63)
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   ID_rs, ID_rt                 ID source register numbers
//   ID_useRS, ID_useRT           ID instruction reads rs / rt
//   ID_useHL, ID_mduOp           ID reads HI/LO / ID is mult or div
//   EX_wr, EX_rd, EX_isLoad      EX writes a GPR, its destination, is a load
//   EX_mduStart, EX_mduDiv       EX launches an MDU op (1 = div, 0 = mult)
//   MEM_wr, MEM_rd               MEM writes a GPR, its destination
//   MUX4Sel, MUX5Sel             rs / rt forward select: 00 GPR, 01 EX, 10 MEM
//   PC_stall, IF_ID_stall        hold PC / hold IF/ID
//   ID_EX_flush                  insert a bubble into ID/EX
//   mdu_busy                     MDU op in progress
module hazard_fwd_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_useRS,
    input  logic       ID_useRT,
    input  logic       ID_useHL,
    input  logic       ID_mduOp,
    input  logic       EX_wr,
    input  logic [4:0] EX_rd,
    input  logic       EX_isLoad,
    input  logic       EX_mduStart,
    input  logic       EX_mduDiv,
    input  logic       MEM_wr,
    input  logic [4:0] MEM_rd,
    output logic [1:0] MUX4Sel,
    output logic [1:0] MUX5Sel,
    output logic       PC_stall,
    output logic       IF_ID_stall,
    output logic       ID_EX_flush,
    output logic       mdu_busy
);

    // Forward select for one source operand. A load in EX has no data yet,
    // so it is never an EX forwarding source; the load-use stall covers it.
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src,
                                           input logic ex_wr, input logic [4:0] ex_rd,
                                           input logic ex_load, input logic mem_wr,
                                           input logic [4:0] mem_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && ex_wr && !ex_load && (ex_rd != 5'd0) && (ex_rd == src)) begin
            sel = 2'b01;
        end else if (use_src && mem_wr && (mem_rd != 5'd0) && (mem_rd == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       load_use;
    logic       mdu_stall;
    logic       mdu_busy_int;
    logic       stall;

    always_comb begin
        fwd_rs = fwd_sel(ID_useRS, ID_rs, EX_wr, EX_rd, EX_isLoad, MEM_wr, MEM_rd);
        fwd_rt = fwd_sel(ID_useRT, ID_rt, EX_wr, EX_rd, EX_isLoad, MEM_wr, MEM_rd);
    end

    always_comb begin
        load_use = EX_isLoad && EX_wr && (EX_rd != 5'd0) &&
                   ((ID_useRS && (EX_rd == ID_rs)) || (ID_useRT && (EX_rd == ID_rt)));
    end

`ifdef HAZARD_MDU_STALL_EN
    localparam logic [5:0] MultLoad = 6'(MULT_CYCLES);
    localparam logic [5:0] DivLoad  = 6'(DIV_CYCLES);

    logic [5:0] mdu_cnt_q;
    logic [5:0] mdu_cnt_d;
    // High for the first cycle after reset so a start held across reset
    // does not launch an op.
    logic       rst_dly_q;

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (EX_mduStart && !rst_dly_q && (mdu_cnt_q <= 6'd1)) begin
            mdu_cnt_d = EX_mduDiv ? DivLoad : MultLoad;
        end else if (mdu_cnt_q != 6'd0) begin
            mdu_cnt_d = mdu_cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_cnt_q <= 6'd0;
            rst_dly_q <= 1'b1;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
            rst_dly_q <= 1'b0;
        end
    end

    always_comb begin
        mdu_busy_int = (mdu_cnt_q != 6'd0);
        mdu_stall    = mdu_busy_int && (ID_useHL || ID_mduOp);
    end
`else
    logic unused_mdu;

    always_comb begin
        mdu_busy_int = 1'b0;
        mdu_stall    = 1'b0;
        unused_mdu   = ^{clk, EX_mduStart, EX_mduDiv, ID_useHL, ID_mduOp};
    end
`endif

    always_comb begin
        stall       = !rst && (load_use || mdu_stall);
        MUX4Sel     = rst ? 2'b00 : fwd_rs;
        MUX5Sel     = rst ? 2'b00 : fwd_rt;
        PC_stall    = stall;
        IF_ID_stall = stall;
        ID_EX_flush = stall;
        mdu_busy    = !rst && mdu_busy_int;
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt;
    logic       ID_useRS, ID_useRT, ID_useHL, ID_mduOp;
    logic       EX_wr;
    logic [4:0] EX_rd;
    logic       EX_isLoad, EX_mduStart, EX_mduDiv;
    logic       MEM_wr;
    logic [4:0] MEM_rd;
    logic [1:0] MUX4Sel, MUX5Sel;
    logic       PC_stall, IF_ID_stall, ID_EX_flush, mdu_busy;

    int n_checks = 0;
    int n_errors = 0;

    hazard_fwd_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .ID_useRS   (ID_useRS),
        .ID_useRT   (ID_useRT),
        .ID_useHL   (ID_useHL),
        .ID_mduOp   (ID_mduOp),
        .EX_wr      (EX_wr),
        .EX_rd      (EX_rd),
        .EX_isLoad  (EX_isLoad),
        .EX_mduStart(EX_mduStart),
        .EX_mduDiv  (EX_mduDiv),
        .MEM_wr     (MEM_wr),
        .MEM_rd     (MEM_rd),
        .MUX4Sel    (MUX4Sel),
        .MUX5Sel    (MUX5Sel),
        .PC_stall   (PC_stall),
        .IF_ID_stall(IF_ID_stall),
        .ID_EX_flush(ID_EX_flush),
        .mdu_busy   (mdu_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All three stall outputs must agree with the expected stall.
    task automatic check_stall(input string tag, input logic exp);
        check_eq({tag, ".pc"},    32'(PC_stall),    32'(exp));
        check_eq({tag, ".ifid"},  32'(IF_ID_stall), 32'(exp));
        check_eq({tag, ".flush"}, 32'(ID_EX_flush), 32'(exp));
    endtask

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_useRS = 1'b0; ID_useRT = 1'b0;
        ID_useHL = 1'b0; ID_mduOp = 1'b0;
        EX_wr = 1'b0; EX_rd = 5'd0; EX_isLoad = 1'b0;
        EX_mduStart = 1'b0; EX_mduDiv = 1'b0;
        MEM_wr = 1'b0; MEM_rd = 5'd0;
    endtask

    // Advance one clock; inputs change just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Forwarding and load-use conditions present during reset must be masked.
        ID_rs = 5'd8; ID_useRS = 1'b1; EX_wr = 1'b1; EX_rd = 5'd8; EX_isLoad = 1'b1;
        step(); step();
        settle();
        check_eq("rst.mux4", 32'(MUX4Sel), 32'd0);
        check_eq("rst.mux5", 32'(MUX5Sel), 32'd0);
        check_eq("rst.busy", 32'(mdu_busy), 32'd0);
        check_stall("rst.stall", 1'b0);

        step();
        rst = 1'b0;
        clear_inputs();
        step();

        // EX beats MEM on the same register.
        EX_wr = 1'b1; EX_rd = 5'd8; MEM_wr = 1'b1; MEM_rd = 5'd8;
        ID_rs = 5'd8; ID_useRS = 1'b1;
        settle();
        check_eq("ex_prio.mux4", 32'(MUX4Sel), 32'd1);
        check_eq("ex_prio.mux5", 32'(MUX5Sel), 32'd0);
        check_stall("ex_prio.stall", 1'b0);

        // rs not read: no forwarding even though it matches.
        step();
        ID_useRS = 1'b0;
        settle();
        check_eq("no_use.mux4", 32'(MUX4Sel), 32'd0);

        // $zero is never forwarded; MEM match on rt forwards from MEM.
        step();
        clear_inputs();
        EX_wr = 1'b1; EX_rd = 5'd0; MEM_wr = 1'b1; MEM_rd = 5'd9;
        ID_rt = 5'd0; ID_useRT = 1'b1;
        settle();
        check_eq("rt0.mux5", 32'(MUX5Sel), 32'd0);
        step();
        ID_rt = 5'd9;
        settle();
        check_eq("rt9.mux5", 32'(MUX5Sel), 32'd2);
        check_eq("rt9.mux4", 32'(MUX4Sel), 32'd0);

        // MEM write disabled: GPR.
        step();
        MEM_wr = 1'b0;
        settle();
        check_eq("memoff.mux5", 32'(MUX5Sel), 32'd0);

        // Load-use: one stall cycle, then the load sits in MEM.
        step();
        clear_inputs();
        EX_isLoad = 1'b1; EX_wr = 1'b1; EX_rd = 5'd5; ID_rt = 5'd5; ID_useRT = 1'b1;
        settle();
        check_stall("lu.stall", 1'b1);
        check_eq("lu.mux5", 32'(MUX5Sel), 32'd0);
        step();
        EX_isLoad = 1'b0; EX_wr = 1'b0; EX_rd = 5'd0;
        MEM_wr = 1'b1; MEM_rd = 5'd5;
        settle();
        check_stall("lu_next.stall", 1'b0);
        check_eq("lu_next.mux5", 32'(MUX5Sel), 32'd2);

        // Load to $zero never stalls.
        step();
        clear_inputs();
        EX_isLoad = 1'b1; EX_wr = 1'b1; EX_rd = 5'd0; ID_rs = 5'd0; ID_useRS = 1'b1;
        settle();
        check_stall("lu_zero.stall", 1'b0);

        // Load-use via rs.
        step();
        EX_rd = 5'd12; ID_rs = 5'd12;
        settle();
        check_stall("lu_rs.stall", 1'b1);
        check_eq("lu_rs.mux4", 32'(MUX4Sel), 32'd0);

        step();
        clear_inputs();

`ifdef HAZARD_MDU_STALL_EN
        // Divide: busy for 32 cycles with mfhi/mflo stalled throughout.
        EX_mduStart = 1'b1; EX_mduDiv = 1'b1;
        step();
        EX_mduStart = 1'b0; EX_mduDiv = 1'b0; ID_useHL = 1'b1;
        for (int i = 0; i < 32; i++) begin
            settle();
            check_eq($sformatf("div.busy%0d", i), 32'(mdu_busy), 32'd1);
            check_eq($sformatf("div.stall%0d", i), 32'(PC_stall), 32'd1);
            step();
        end
        settle();
        check_eq("div.done.busy", 32'(mdu_busy), 32'd0);
        check_stall("div.done.stall", 1'b0);

        // Multiply: 5 busy cycles, ID_mduOp also stalls.
        step();
        clear_inputs();
        EX_mduStart = 1'b1;
        step();
        EX_mduStart = 1'b0; ID_mduOp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq($sformatf("mul.busy%0d", i), 32'(mdu_busy), 32'd1);
            check_stall($sformatf("mul.stall%0d", i), 1'b1);
            step();
        end
        settle();
        check_eq("mul.done.busy", 32'(mdu_busy), 32'd0);

        // Busy without an HI/LO reader: no stall.
        step();
        clear_inputs();
        EX_mduStart = 1'b1;
        step();
        EX_mduStart = 1'b0;
        settle();
        check_eq("mul_nouse.busy", 32'(mdu_busy), 32'd1);
        check_stall("mul_nouse.stall", 1'b0);

        // Reset mid-multiply at count 3 aborts the op (counts 5,4,3).
        step();
        step();
        ID_useHL = 1'b1;
        rst = 1'b1;
        settle();
        check_eq("mulrst.during.busy", 32'(mdu_busy), 32'd0);
        step();
        rst = 1'b0;
        settle();
        check_eq("mulrst.after.busy", 32'(mdu_busy), 32'd0);
        check_stall("mulrst.after.stall", 1'b0);

        // A start held across reset is ignored on the first cycle after it.
        step();
        clear_inputs();
        rst = 1'b1; EX_mduStart = 1'b1;
        step();
        rst = 1'b0;
        step();
        EX_mduStart = 1'b0; ID_useHL = 1'b1;
        settle();
        check_eq("rst_start.busy", 32'(mdu_busy), 32'd0);
        check_stall("rst_start.stall", 1'b0);

        // Load-use and MDU stall together give one ordinary stall.
        step();
        clear_inputs();
        EX_mduStart = 1'b1;
        step();
        EX_mduStart = 1'b0; ID_useHL = 1'b1;
        EX_isLoad = 1'b1; EX_wr = 1'b1; EX_rd = 5'd3; ID_rs = 5'd3; ID_useRS = 1'b1;
        settle();
        check_stall("both.stall", 1'b1);
`else
        // MDU logic not built: starts and HI/LO readers have no effect.
        EX_mduStart = 1'b1; EX_mduDiv = 1'b0;
        step();
        EX_mduStart = 1'b0; ID_useHL = 1'b1; ID_mduOp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("nomdu.busy%0d", i), 32'(mdu_busy), 32'd0);
            check_stall($sformatf("nomdu.stall%0d", i), 1'b0);
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
